cart_rd_if: RTL and testbench
=============================

CART_RD_IF -- requirements
Module: cart_rd_if

Interface
Parameters (name, default, meaning):
REQ-001 SETUP_CYC, 2: cycles between address drive and read strobe; legal range 1..15.
REQ-002 STROBE_CYC, 4: cycles with cart_rd_n low; legal range 1..15.
REQ-003 HOLD_CYC, 1: cycles with strobe and select released before returning idle; legal range 1..15.
Ports (name, direction, width, meaning):
REQ-004 clk_8m  input  1  8 MHz system clock; the only clock.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rom_addr  input  16  cartridge byte address requested by the consumer.
REQ-007 rom_rd  input  1  one-cycle read request strobe.
REQ-008 rom_data  output  8  last byte read; stable while rom_bsy is low.
REQ-009 rom_bsy  output  1  high while a read is accepted or in progress.
REQ-010 rom_err  output  1  one-cycle pulse when a verified read fails (see Configuration).
REQ-011 cart_a  output  16  cartridge address bus.
REQ-012 cart_d_in  input  8  cartridge data bus, input only.
REQ-013 cart_cs_n  output  1  cartridge select, active-low.
REQ-014 cart_rd_n  output  1  cartridge read strobe, active-low.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, driven by one 4-bit phase counter.
REQ-016 In IDLE, rom_rd high at a clock edge SHALL latch rom_addr into cart_a and enter SETUP.
REQ-017 rom_bsy SHALL equal (state != IDLE) OR rom_rd, combinationally, so there is no gap between request and busy.
REQ-018 A rom_rd asserted outside IDLE SHALL be ignored; it is neither queued nor allowed to alter cart_a.
REQ-019 cart_cs_n SHALL be low in SETUP and STROBE, and high in IDLE and HOLD.
REQ-020 cart_rd_n SHALL be low only in STROBE.
REQ-021 SETUP, STROBE and HOLD SHALL last exactly SETUP_CYC, STROBE_CYC and HOLD_CYC cycles respectively.
REQ-022 cart_d_in SHALL be captured at the clock edge that ends the last STROBE cycle.
REQ-023 Without verification, the captured byte SHALL update rom_data at that edge.
REQ-024 Read latency SHALL be SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (default 7), counted from the edge that samples rom_rd to the first cycle with rom_bsy low.
REQ-025 rom_data SHALL change only at a capture edge, and SHALL hold its value across idle periods and ignored requests.
REQ-026 cart_a SHALL keep the last address after completion, until the next accepted request.
REQ-027 rom_rd arriving in the first IDLE cycle after HOLD SHALL be accepted, giving back-to-back reads with no dead cycle.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state IDLE, counter 0, cart_a 0x0000, rom_data 0x00, cart_cs_n 1, cart_rd_n 1, rom_err 0, and retry count 0.
REQ-029 A transaction interrupted by reset SHALL be abandoned without a data update.
REQ-030 After reset, rom_bsy SHALL be high only if rom_rd is high.
REQ-031 The first edge with rst_n high SHALL be able to accept a request.

Configuration
REQ-032 With CART_RD_VERIFY_EN defined, each transaction SHALL perform two full SETUP/STROBE/HOLD reads of the same address.
REQ-033 With CART_RD_VERIFY_EN defined and equal results, rom_data SHALL be updated from the second read, and the consumer-visible latency SHALL be twice the REQ-024 latency.
REQ-034 With CART_RD_VERIFY_EN defined and unequal results, the pair SHALL be repeated, up to 3 pairs in total.
REQ-035 With CART_RD_VERIFY_EN defined, if the third pair still mismatches, rom_data SHALL take the last read, rom_err SHALL pulse for one cycle coincident with rom_bsy falling, and the retry count SHALL clear.
REQ-036 Without CART_RD_VERIFY_EN, REQ-032..035 SHALL not exist, each transaction SHALL be a single read, and rom_err SHALL be tied 0.

Verification
REQ-037 Single read: rom_addr=0x0104, rom_rd for 1 cycle, cart_d_in=0xCE -> cart_a=0x0104; cs_n low for 6 cycles; rd_n low for 4 cycles; rom_bsy high for 7 cycles; then rom_data=0xCE.
REQ-038 Ignored request: rom_rd pulsed with 0x0200 in the 3rd busy cycle of a read of 0x0105 -> cart_a stays 0x0105 and exactly one transaction occurs.
REQ-039 Back-to-back: requests for 0x0104..0x0133, each issued in the first cycle with rom_bsy low, with a model cart -> 48 correct bytes, each issue-to-completion exactly 7 cycles (14 with CART_RD_VERIFY_EN defined, no mismatches).
REQ-040 Reset mid-STROBE: rst_n low during cycle 4 of a read, rom_data previously 0x5A -> outputs immediately go to reset values, rom_data=0x00, and no capture occurs.
REQ-041 Verify build: cart_d_in alternates 0x11/0x22 on each read -> 6 reads, rom_data=0x22, one rom_err pulse, rom_bsy high for 42 cycles.
REQ-042 Parameter sweep: SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 -> latency 3 cycles and rd_n low for exactly 1 cycle.

Source files
------------

// File: rtl/cart_rd_if.sv
// Cartridge ROM read sequencer: one request produces a SETUP/STROBE/HOLD bus cycle on the cart bus.
// Optional double-read verification with retries is enabled by defining CART_RD_VERIFY_EN.
module cart_rd_if #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk_8m,
    input  logic        rst_n,
    input  logic [15:0] rom_addr,
    input  logic        rom_rd,
    output logic [7:0]  rom_data,
    output logic        rom_bsy,
    output logic        rom_err,
    output logic [15:0] cart_a,
    input  logic [7:0]  cart_d_in,
    output logic        cart_cs_n,
    output logic        cart_rd_n
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLast   = 4'(HOLD_CYC - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] cart_a_q, cart_a_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;

`ifdef CART_RD_VERIFY_EN
    logic       pass_q, pass_d;         // 0: first read of a pair, 1: second read
    logic [7:0] first_q, first_d;
    logic [1:0] retry_q, retry_d;
    logic       fin_q, fin_d;           // pair finished, return to idle after HOLD
    logic       err_pend_q, err_pend_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cart_a_d   = cart_a_q;
        rom_data_d = rom_data_q;
`ifdef CART_RD_VERIFY_EN
        pass_d     = pass_q;
        first_d    = first_q;
        retry_d    = retry_q;
        fin_d      = fin_q;
        err_pend_d = err_pend_q;
        err_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (rom_rd) begin
                    state_d  = StSetup;
                    cnt_d    = 4'd0;
                    cart_a_d = rom_addr;
`ifdef CART_RD_VERIFY_EN
                    pass_d   = 1'b0;
`endif
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StStrobe;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == StrobeLast) begin
                    state_d = StHold;
                    cnt_d   = 4'd0;
`ifdef CART_RD_VERIFY_EN
                    if (!pass_q) begin
                        first_d = cart_d_in;
                    end else if ((cart_d_in == first_q) || (retry_q == 2'd2)) begin
                        // Third mismatching pair still delivers the last byte, flagged as error
                        rom_data_d = cart_d_in;
                        fin_d      = 1'b1;
                        err_pend_d = (cart_d_in != first_q);
                    end else begin
                        fin_d      = 1'b0;
                        err_pend_d = 1'b0;
                    end
`else
                    rom_data_d = cart_d_in;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = 4'd0;
`ifdef CART_RD_VERIFY_EN
                    if (!pass_q) begin
                        state_d = StSetup;
                        pass_d  = 1'b1;
                    end else if (fin_q) begin
                        state_d    = StIdle;
                        pass_d     = 1'b0;
                        retry_d    = 2'd0;
                        fin_d      = 1'b0;
                        err_pend_d = 1'b0;
                        err_d      = err_pend_q;
                    end else begin
                        state_d = StSetup;
                        pass_d  = 1'b0;
                        retry_d = retry_q + 2'd1;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Strobes are registered from next state so the cart bus never sees decode glitches
        cs_n_d = !((state_d == StSetup) || (state_d == StStrobe));
        rd_n_d = (state_d != StStrobe);
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cart_a_q   <= 16'h0000;
            rom_data_q <= 8'h00;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
`ifdef CART_RD_VERIFY_EN
            pass_q     <= 1'b0;
            first_q    <= 8'h00;
            retry_q    <= 2'd0;
            fin_q      <= 1'b0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cart_a_q   <= cart_a_d;
            rom_data_q <= rom_data_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
`ifdef CART_RD_VERIFY_EN
            pass_q     <= pass_d;
            first_q    <= first_d;
            retry_q    <= retry_d;
            fin_q      <= fin_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
`endif
        end
    end

    assign rom_bsy   = (state_q != StIdle) || rom_rd;
    assign rom_data  = rom_data_q;
    assign cart_a    = cart_a_q;
    assign cart_cs_n = cs_n_q;
    assign cart_rd_n = rd_n_q;
`ifdef CART_RD_VERIFY_EN
    assign rom_err   = err_q;
`else
    assign rom_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cart_rd_if.sv
// Directed bench for cart_rd_if: vector table plus sequences for ignored requests,
// back-to-back reads, reset mid-strobe, verify retries and a 1/1/1 timing instance.
`timescale 1ns/100ps
module tb_cart_rd_if;

`ifdef CART_RD_VERIFY_EN
    localparam int RD_PER = 2;
`else
    localparam int RD_PER = 1;
`endif
    localparam int LAT = 7 * RD_PER;

    logic        clk_8m;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic        rom_bsy;
    logic        rom_err;
    logic [15:0] cart_a;
    logic [7:0]  cart_d_in;
    logic        cart_cs_n;
    logic        cart_rd_n;

    logic [15:0] s_addr;
    logic        s_rd;
    logic [7:0]  s_data;
    logic        s_bsy;
    logic        s_err;
    logic [15:0] s_a;
    logic        s_cs_n;
    logic        s_rd_n;

    cart_rd_if dut (
        .clk_8m    (clk_8m),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_data  (rom_data),
        .rom_bsy   (rom_bsy),
        .rom_err   (rom_err),
        .cart_a    (cart_a),
        .cart_d_in (cart_d_in),
        .cart_cs_n (cart_cs_n),
        .cart_rd_n (cart_rd_n)
    );

    cart_rd_if #(
        .SETUP_CYC  (1),
        .STROBE_CYC (1),
        .HOLD_CYC   (1)
    ) dut_fast (
        .clk_8m    (clk_8m),
        .rst_n     (rst_n),
        .rom_addr  (s_addr),
        .rom_rd    (s_rd),
        .rom_data  (s_data),
        .rom_bsy   (s_bsy),
        .rom_err   (s_err),
        .cart_a    (s_a),
        .cart_d_in (8'h9B),
        .cart_cs_n (s_cs_n),
        .cart_rd_n (s_rd_n)
    );

    initial clk_8m = 1'b0;
    always #62.5 clk_8m = ~clk_8m;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cart model: 0 fixed byte, 1 address-derived byte, 2 alternating 0x11/0x22 per read
    int         dmode = 0;
    logic [7:0] fix_d = 8'h00;
    int         alt_base = 0;
    int         strobes = 0;

    function automatic logic [7:0] cart_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always_comb begin
        cart_d_in = fix_d;
        if (dmode == 1) cart_d_in = cart_model(cart_a);
        else if (dmode == 2) cart_d_in = (((strobes - alt_base) & 1) != 0) ? 8'h11 : 8'h22;
    end

    int   cs_cnt = 0;
    int   rd_cnt = 0;
    int   err_cnt = 0;
    int   err_bsy = 0;
    int   s_rdlow = 0;
    logic prev_rd_n = 1'b1;

    always @(negedge clk_8m) begin
        if (!cart_cs_n) cs_cnt++;
        if (!cart_rd_n) rd_cnt++;
        if (prev_rd_n && !cart_rd_n) strobes++;
        prev_rd_n = cart_rd_n;
        if (rom_err) begin
            err_cnt++;
            if (rom_bsy) err_bsy++;
        end
        if (!s_rd_n) s_rdlow++;
    end

    // Called at a negedge; returns at the first negedge with rom_bsy low
    task automatic do_read(input logic [15:0] a, output int lat);
        rom_addr = a;
        rom_rd   = 1'b1;
        @(negedge clk_8m);
        rom_rd = 1'b0;
        lat    = 0;
        while (rom_bsy && lat < 100) begin
            lat++;
            @(negedge clk_8m);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        int          exp_lat;
        int          exp_cs;
        int          exp_rd;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, n, cs0, rd0, st0, e0;

        vecs[0] = '{16'h0104, 8'hCE, 16'h0104, 8'hCE, LAT, 6 * RD_PER, 4 * RD_PER};
        vecs[1] = '{16'hFFFF, 8'h00, 16'hFFFF, 8'h00, LAT, 6 * RD_PER, 4 * RD_PER};
        vecs[2] = '{16'h0000, 8'hFF, 16'h0000, 8'hFF, LAT, 6 * RD_PER, 4 * RD_PER};
        vecs[3] = '{16'hA5A5, 8'h3C, 16'hA5A5, 8'h3C, LAT, 6 * RD_PER, 4 * RD_PER};

        rst_n    = 1'b0;
        rom_rd   = 1'b0;
        rom_addr = 16'h0000;
        s_rd     = 1'b0;
        s_addr   = 16'h0000;

        repeat (3) @(negedge clk_8m);
        #1;
        chk("rst_bsy", rom_bsy, 0);
        chk("rst_cs_n", cart_cs_n, 1);
        chk("rst_rd_n", cart_rd_n, 1);
        chk("rst_cart_a", cart_a, 0);
        chk("rst_rom_data", rom_data, 0);
        chk("rst_rom_err", rom_err, 0);
        rom_rd = 1'b1;
        #1;
        chk("rst_bsy_follows_rd", rom_bsy, 1);
        rom_rd = 1'b0;

        // First vector issued on the same negedge as reset release
        @(negedge clk_8m);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fix_d = vecs[i].data;
            cs0 = cs_cnt;
            rd0 = rd_cnt;
            st0 = strobes;
            do_read(vecs[i].addr, lat);
            chk("vec_latency", lat, vecs[i].exp_lat);
            chk("vec_rom_data", rom_data, vecs[i].exp_d);
            chk("vec_cart_a", cart_a, vecs[i].exp_a);
            chk("vec_cs_low", cs_cnt - cs0, vecs[i].exp_cs);
            chk("vec_rd_low", rd_cnt - rd0, vecs[i].exp_rd);
            chk("vec_strobes", strobes - st0, RD_PER);
        end

        // Request in the 3rd busy cycle must be ignored
        fix_d    = 8'h3D;
        st0      = strobes;
        rom_addr = 16'h0105;
        rom_rd   = 1'b1;
        @(negedge clk_8m);
        rom_rd = 1'b0;
        @(negedge clk_8m);
        rom_addr = 16'h0200;
        rom_rd   = 1'b1;
        @(negedge clk_8m);
        rom_rd   = 1'b0;
        rom_addr = 16'h0000;
        n = 2;
        while (rom_bsy && n < 100) begin
            n++;
            @(negedge clk_8m);
        end
        chk("ign_latency", n, LAT);
        chk("ign_cart_a", cart_a, 16'h0105);
        chk("ign_rom_data", rom_data, 8'h3D);
        fix_d = 8'hE7;
        repeat (5) @(negedge clk_8m);
        chk("ign_idle_bsy", rom_bsy, 0);
        chk("ign_strobes", strobes - st0, RD_PER);
        chk("idle_cart_a_hold", cart_a, 16'h0105);
        chk("idle_rom_data_hold", rom_data, 8'h3D);

        // Back-to-back reads with the model cart
        dmode = 1;
        for (int i = 0; i < 48; i++) begin
            logic [15:0] a;
            a = 16'h0104 + 16'(i);
            do_read(a, lat);
            chk("b2b_latency", lat, LAT);
            chk("b2b_rom_data", rom_data, cart_model(a));
        end

        // Reset during cycle 4 (second STROBE cycle)
        dmode = 0;
        fix_d = 8'h5A;
        do_read(16'h0300, lat);
        chk("pre_rst_data", rom_data, 8'h5A);
        fix_d    = 8'h77;
        st0      = strobes;
        rom_addr = 16'h0301;
        rom_rd   = 1'b1;
        @(negedge clk_8m);
        rom_rd = 1'b0;
        repeat (3) @(negedge clk_8m);
        chk("mid_in_strobe", cart_rd_n, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rom_data, 8'h00);
        chk("mid_rst_cart_a", cart_a, 16'h0000);
        chk("mid_rst_cs_n", cart_cs_n, 1);
        chk("mid_rst_rd_n", cart_rd_n, 1);
        chk("mid_rst_bsy", rom_bsy, 0);
        chk("mid_rst_err", rom_err, 0);
        repeat (3) @(negedge clk_8m);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_8m);
        chk("post_rst_data", rom_data, 8'h00);
        chk("post_rst_strobes", strobes - st0, 1);
        chk("post_rst_bsy", rom_bsy, 0);

`ifdef CART_RD_VERIFY_EN
        // Every pair mismatches: three pairs, last byte kept, one error pulse
        dmode    = 2;
        alt_base = strobes;
        st0      = strobes;
        e0       = err_cnt;
        do_read(16'h0400, lat);
        chk("ver_latency", lat, 42);
        chk("ver_strobes", strobes - st0, 6);
        chk("ver_rom_data", rom_data, 8'h22);
        chk("ver_cart_a", cart_a, 16'h0400);
        repeat (3) @(negedge clk_8m);
        chk("ver_err_pulses", err_cnt - e0, 1);
        dmode = 0;
        fix_d = 8'h44;
        e0    = err_cnt;
        do_read(16'h0401, lat);
        chk("ver_retry_clear_lat", lat, 14);
        chk("ver_retry_clear_data", rom_data, 8'h44);
        repeat (2) @(negedge clk_8m);
        chk("ver_no_err", err_cnt - e0, 0);
`endif

        // 1/1/1 timing instance
        rd0    = s_rdlow;
        s_addr = 16'h1234;
        s_rd   = 1'b1;
        @(negedge clk_8m);
        s_rd = 1'b0;
        n    = 0;
        while (s_bsy && n < 100) begin
            n++;
            @(negedge clk_8m);
        end
        chk("fast_latency", n, 3 * RD_PER);
        chk("fast_rd_low", s_rdlow - rd0, RD_PER);
        chk("fast_rom_data", s_data, 8'h9B);
        chk("fast_cart_a", s_a, 16'h1234);

        chk("err_while_bsy", err_bsy, 0);
`ifndef CART_RD_VERIFY_EN
        chk("err_never", err_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
